// File: rtl/mult_share_pkg.sv
// Shared types and defaults for the round-robin shared multiplier.
// stage_t is sized for the default configuration (DEF_NREQ requesters, DEF_DW operands).
package mult_share_pkg;

  localparam int DEF_NREQ    = 32'd4;
  localparam int DEF_DW      = 32'd8;
  localparam int DEF_MUL_LAT = 32'd2;

  function automatic int id_w(input int n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

  localparam int DEF_ID_W = id_w(DEF_NREQ);

  typedef struct packed {
    logic                valid;
    logic [DEF_ID_W-1:0] id;
    logic [DEF_DW-1:0]   a;
    logic [DEF_DW-1:0]   b;
  } stage_t;

endpackage

// File: rtl/mult_share_arb_pipe.sv
// Registered unsigned multiplier: operand stage followed by MUL_LAT product stages,
// the last of which is the response register. Valid and id travel with the data.
module mult_pipe
  import mult_share_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int ID_W    = DEF_ID_W,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  stage_t          op_i,
  output logic            out_valid_o,
  output logic [ID_W-1:0] out_id_o,
  output logic [2*DW-1:0] out_data_o,
  output logic            busy_o
);

  stage_t          op_q;
  logic [MUL_LAT:1] v_q;
  logic [ID_W-1:0] id_q [MUL_LAT:1];
  logic [2*DW-1:0] p_q  [MUL_LAT:1];
  logic [2*DW-1:0] prod_s;
  logic            busy_s;

  // zero-extended product of the captured operands
  always_comb begin
    prod_s = (2*DW)'(op_q.a) * (2*DW)'(op_q.b);
  end

  // pipeline registers; data only moves with its valid so the last stage holds
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      op_q <= '0;
      v_q  <= '0;
      for (int i = 1; i <= MUL_LAT; i++) begin
        id_q[i] <= '0;
        p_q[i]  <= '0;
      end
    end else begin
      op_q   <= op_i;
      v_q[1] <= op_q.valid;
      if (op_q.valid) begin
        id_q[1] <= op_q.id;
        p_q[1]  <= prod_s;
      end
      for (int i = 2; i <= MUL_LAT; i++) begin
        v_q[i] <= v_q[i-1];
        if (v_q[i-1]) begin
          id_q[i] <= id_q[i-1];
          p_q[i]  <= p_q[i-1];
        end
      end
    end
  end

  // in flight = accepted but not yet presented on the response register
  always_comb begin
    busy_s = op_q.valid;
    for (int i = 1; i < MUL_LAT; i++) begin
      busy_s = busy_s | v_q[i];
    end
  end

  assign out_valid_o = v_q[MUL_LAT];
  assign out_id_o    = id_q[MUL_LAT];
  assign out_data_o  = p_q[MUL_LAT];
  assign busy_o      = busy_s;

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one pipelined unsigned multiplier among NREQ requesters.
// Grant is combinational; responses come back tagged with the requester index.
module mult_share_arb
  import mult_share_pkg::*;
#(
  parameter  int NREQ    = DEF_NREQ,
  parameter  int DW      = DEF_DW,
  parameter  int MUL_LAT = DEF_MUL_LAT,
  localparam int ID_W    = id_w(NREQ)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             lock_i,
  input  logic [NREQ-1:0]  req_valid_i,
  input  logic [NREQ*DW-1:0] req_a_i,
  input  logic [NREQ*DW-1:0] req_b_i,
  output logic [NREQ-1:0]  req_ready_o,
  output logic             resp_valid_o,
  output logic [ID_W-1:0]  resp_id_o,
  output logic [2*DW-1:0]  resp_data_o,
  output logic             busy_o
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;
  logic [ID_W-1:0] cand_s;
  logic [ID_W-1:0] gnt_idx_s;
  logic            gnt_found_s;
  logic            xfer_s;
  logic [NREQ-1:0] ready_s;
  stage_t          op_s;

  // scan from ptr upward; NREQ is a power of two so ID_W-bit wrap is the modulo
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = ptr_q;
    cand_s      = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      cand_s = ptr_q + ID_W'(i);
      if (!gnt_found_s && req_valid_i[cand_s]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = cand_s;
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // grant, transfer and next pointer
  always_comb begin
    ready_s = '0;
    xfer_s  = lock_i & rst_n_i & gnt_found_s;
    if (xfer_s) begin
      ready_s[gnt_idx_s] = 1'b1;
      ptr_d              = gnt_idx_s + ID_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // select the granted requester's operands
  always_comb begin
    op_s       = '0;
    op_s.valid = xfer_s;
    op_s.id    = gnt_idx_s;
    for (int i = 0; i < NREQ; i++) begin
      if (ID_W'(i) == gnt_idx_s) begin
        op_s.a = req_a_i[i*DW +: DW];
        op_s.b = req_b_i[i*DW +: DW];
      end else begin
        op_s.a = op_s.a;
      end
    end
  end

  // round-robin pointer
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  mult_pipe #(
    .DW      (DW),
    .ID_W    (ID_W),
    .MUL_LAT (MUL_LAT)
  ) u_pipe (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .op_i        (op_s),
    .out_valid_o (resp_valid_o),
    .out_id_o    (resp_id_o),
    .out_data_o  (resp_data_o),
    .busy_o      (busy_o)
  );

  assign req_ready_o = ready_s;

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb with a queue-based reference model checked every cycle.
module tb_mult_share_arb;
  import mult_share_pkg::*;

  localparam int NREQ    = 4;
  localparam int DW      = 8;
  localparam int MUL_LAT = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        lock  = 1'b0;
  logic [3:0]  valid = 4'd0;
  logic [31:0] a_bus = 32'd0;
  logic [31:0] b_bus = 32'd0;
  logic [3:0]  ready;
  logic        rv;
  logic [1:0]  rid;
  logic [15:0] rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mult_share_arb #(.NREQ(NREQ), .DW(DW), .MUL_LAT(MUL_LAT)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .lock_i       (lock),
    .req_valid_i  (valid),
    .req_a_i      (a_bus),
    .req_b_i      (b_bus),
    .req_ready_o  (ready),
    .resp_valid_o (rv),
    .resp_id_o    (rid),
    .resp_data_o  (rdata),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Reference model: pending responses with the edge at which they appear.
  typedef struct {
    int due;
    int id;
    int data;
  } exp_t;

  exp_t q[$];
  int   m_ptr  = 0;
  int   m_rv   = 0;
  int   m_id   = 0;
  int   m_data = 0;
  int   edge_n = 0;
  bit   m_init = 1'b0;

  always @(negedge clk) begin
    int g;
    int pa;
    int pb;
    g = -1;
    if (rst_n && lock) begin
      for (int i = 0; i < NREQ; i++) begin
        int k;
        k = (m_ptr + i) % NREQ;
        if (g < 0 && valid[k]) g = k;
      end
    end
    if (m_init) begin
      check("model ready", int'(ready), (g >= 0) ? (1 << g) : 0);
      check("model resp_valid", int'(rv), m_rv);
      check("model resp_id", int'(rid), m_id);
      check("model resp_data", int'(rdata), m_data);
      check("model busy", int'(busy), (q.size() > 0) ? 1 : 0);
    end
    if (!rst_n) begin
      q.delete();
      m_ptr  = 0;
      m_rv   = 0;
      m_id   = 0;
      m_data = 0;
      m_init = 1'b1;
    end else begin
      m_rv = 0;
      if (q.size() > 0 && q[0].due == edge_n + 1) begin
        m_rv   = 1;
        m_id   = q[0].id;
        m_data = q[0].data;
        void'(q.pop_front());
      end
      if (g >= 0) begin
        pa = int'(a_bus[g*8 +: 8]);
        pb = int'(b_bus[g*8 +: 8]);
        q.push_back('{edge_n + 1 + MUL_LAT, g, pa * pb});
        m_ptr = (g + 1) % NREQ;
      end
    end
    edge_n++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int k, input int a, input int b);
    a_bus[k*8 +: 8] = a[7:0];
    b_bus[k*8 +: 8] = b[7:0];
  endtask

  task automatic do_single(input string name, input int k, input int a, input int b,
                           input int exp);
    valid    = 4'd0;
    valid[k] = 1'b1;
    set_op(k, a, b);
    #1;
    check({name, " ready"}, int'(ready), 1 << k);
    tick();
    valid = 4'd0;
    tick();
    check({name, " early"}, int'(rv), 0);
    tick();
    check({name, " valid"}, int'(rv), 1);
    check({name, " id"}, int'(rid), k);
    check({name, " data"}, int'(rdata), exp);
    tick();
    check({name, " pulse"}, int'(rv), 0);
    check({name, " hold"}, int'(rdata), exp);
  endtask

  int exp_d [5] = '{3, 6, 9, 12, 3};

  initial begin
    // contention: all valid from reset, operands (k+1, 3)
    rst_n = 1'b0;
    lock  = 1'b1;
    valid = 4'b1111;
    for (int k = 0; k < NREQ; k++) set_op(k, k + 1, 3);
    tick();
    tick();
    check("reset ready", int'(ready), 0);
    check("reset resp_valid", int'(rv), 0);
    check("reset resp_data", int'(rdata), 0);
    check("reset resp_id", int'(rid), 0);
    check("reset busy", int'(busy), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("rr grant", int'(ready), 1 << (i % 4));
      tick();
      if (i >= 2) begin
        check("rr resp_valid", int'(rv), 1);
        check("rr resp_id", int'(rid), (i - 2) % 4);
        check("rr resp_data", int'(rdata), exp_d[i-2]);
      end
    end
    valid = 4'd0;
    for (int j = 3; j < 5; j++) begin
      tick();
      check("rr tail valid", int'(rv), 1);
      check("rr tail id", int'(rid), j % 4);
      check("rr tail data", int'(rdata), exp_d[j]);
    end
    tick();
    check("rr drained busy", int'(busy), 0);

    do_single("single", 0, 1, 2, 2);

    // back-to-back from requester 1
    valid = 4'b0010;
    set_op(1, 10, 20);
    #1;
    check("b2b ready0", int'(ready), 4'b0010);
    tick();
    set_op(1, 11, 22);
    #1;
    check("b2b ready1", int'(ready), 4'b0010);
    tick();
    valid = 4'd0;
    tick();
    check("b2b resp0 valid", int'(rv), 1);
    check("b2b resp0 id", int'(rid), 1);
    check("b2b resp0 data", int'(rdata), 200);
    tick();
    check("b2b resp1 valid", int'(rv), 1);
    check("b2b resp1 id", int'(rid), 1);
    check("b2b resp1 data", int'(rdata), 242);
    tick();

    do_single("max", 2, 255, 255, 65025);
    do_single("zero", 3, 0, 200, 0);
    do_single("by_one", 0, 255, 1, 255);

    // lock gating
    lock  = 1'b0;
    valid = 4'b0100;
    set_op(2, 5, 6);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("lock ready", int'(ready), 0);
      tick();
      check("lock no resp", int'(rv), 0);
    end
    lock = 1'b1;
    #1;
    check("lock grant", int'(ready), 4'b0100);
    tick();
    valid = 4'd0;
    tick();
    tick();
    check("lock resp valid", int'(rv), 1);
    check("lock resp id", int'(rid), 2);
    check("lock resp data", int'(rdata), 30);
    tick();

    // reset mid-flight
    valid = 4'b0001;
    set_op(0, 7, 9);
    #1;
    check("midrst ready", int'(ready), 4'b0001);
    tick();
    valid = 4'd0;
    check("midrst busy before", int'(busy), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst resp_valid", int'(rv), 0);
    check("midrst busy", int'(busy), 0);
    check("midrst data", int'(rdata), 0);
    check("midrst id", int'(rid), 0);
    tick();
    check("midrst no resp1", int'(rv), 0);
    tick();
    check("midrst no resp2", int'(rv), 0);
    valid = 4'b1111;
    #1;
    check("midrst ptr zero", int'(ready), 4'b0001);
    tick();
    valid = 4'd0;
    tick();
    tick();
    check("post rst resp id", int'(rid), 0);
    check("post rst resp data", int'(rdata), 63);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_share_arb.md
Name: mult_share_arb

Overview:
- Shares one pipelined unsigned 8x8 multiplier among NREQ requesters using round-robin arbitration and a valid/ready handshake.
- Sits between the test/datapath logic in top and the multiplier datapath, in the clk_1m domain after PLL lock.
- Accepts at most one operation per cycle and returns each product tagged with the requester ID.

Parameters:
- NREQ, 4, number of requesters; power of two, 2..8.
- DW, 8, operand width; product width is 2*DW.
- MUL_LAT, 2, multiplier pipeline depth in cycles; range 1..4.

Ports:
- clk_i  in  1  clock (clk_1m domain).
- rst_n_i  in  1  synchronous, active-low reset; sampled on the rising edge of clk_i.
- lock_i  in  1  PLL lock; no new requests are granted while low.
- req_valid_i  in  NREQ  per-requester request valid.
- req_a_i  in  NREQ*DW  operand A; requester k uses bits [k*DW +: DW].
- req_b_i  in  NREQ*DW  operand B, same packing as req_a_i.
- req_ready_o  out  NREQ  one-hot grant; at most one bit set.
- resp_valid_o  out  1  product valid, one-cycle pulse per result.
- resp_id_o  out  ID_W  requester index of the product.
- resp_data_o  out  2*DW  unsigned product.
- busy_o  out  1  at least one operation is in flight.

Behaviour:
- Handshake: a transfer occurs on a rising edge where req_valid_i[k] and req_ready_o[k] are both high.
- req_ready_o is combinational from req_valid_i, the RR pointer and lock_i; it is never asserted for a requester whose valid is low.
- Requesters hold a/b stable while valid is high and not yet accepted; no valid drop is required after acceptance.
- Arbitration:
  - Round-robin pointer ptr (ID_W bits) marks the highest-priority requester.
  - The grant goes to the first k with valid high, scanning ptr, ptr+1, ... modulo NREQ.
  - After a transfer to k, ptr <= (k+1) mod NREQ; otherwise ptr holds.
- lock_i low: req_ready_o = 0; ptr holds; in-flight operations still drain.
- Pipeline:
  - An accepted operation enters stage 1 holding a, b and id.
  - The product is computed across MUL_LAT stages.
  - A transfer at edge N gives resp_valid_o=1 with data and id for exactly one cycle after edge N+MUL_LAT.
- Throughput is 1 per cycle; there is no backpressure on the response. Consumers must always accept.
- Response outputs:
  - resp_data_o and resp_id_o are registered and hold their last value while resp_valid_o=0.
  - resp_data_o is a zero-extended unsigned multiply; no overflow is possible.
- busy_o is the OR of all pipeline-stage valid bits; it is 0 once the pipeline is empty.
- Reset (synchronous, rst_n_i=0 at a rising edge):
  - ptr=0, all stage valids=0, resp_valid_o=0, resp_id_o=0, resp_data_o=0, busy_o=0.
  - req_ready_o is forced to 0 during reset.
- Reset mid-operation: in-flight operations are discarded and no response is produced for them.
- Simultaneous events: reset dominates lock_i and requests. A request and a response in the same cycle are independent.

Decomposition:
- Package mult_share_pkg holds:
  - ID_W = $clog2(NREQ) helper function.
  - A stage record type {valid, id, a, b}.
  - The default DW and MUL_LAT constants.
- One sub-module, mult_pipe, is the MUL_LAT-deep registered multiplier.
  - It carries the valid and id sideband alongside the data.
  - It has the same clock and synchronous active-low reset.
- The arbiter (RR pointer, grant, packing) stays in mult_share_arb.

Test Plan:
- Single request: req 0 with a=1, b=2, lock=1 -> ready[0] in the same cycle; resp_valid=1, id=0, data=2 exactly 2 cycles after acceptance.
- Back-to-back from one requester: req 1 issues (10,20) then (11,22) on consecutive cycles -> responses 200 then 242 on consecutive cycles, both with id=1.
- Contention: all four valid continuously from reset, with operands (k+1, 3) -> grant order 0,1,2,3,0; products 3,6,9,12,3 with matching ids.
- Boundary values: (255,255) -> 65025; (0,200) -> 0; (255,1) -> 255.
- Lock gating: lock_i=0 with req 2 valid -> ready=0 for 5 cycles, no response. Raise lock -> grant on that cycle, response after MUL_LAT cycles.
- Reset mid-flight: accept (7,9), assert rst_n_i=0 one cycle later for 1 cycle -> no resp_valid pulse, busy_o=0, data=0, ptr=0 afterwards.
